// File: rtl/pipe_cleaner_pkg.sv
// Shared definitions for the elastic pipe cleaner.
//   WIDTH_D / DEPTH_D / CNT_W_D : default parameter values.
//   occ_w()                     : width needed to hold an occupancy of 0..DEPTH.
//   sat_add()                   : saturating add that clamps at a caller-given maximum.
package pipe_cleaner_pkg;

  localparam int WIDTH_D = 8;
  localparam int DEPTH_D = 4;
  localparam int CNT_W_D = 8;

  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // a is assumed to already be <= max_v. Testing b against the remaining
  // headroom avoids computing a+b, which could overflow.
  function automatic int unsigned sat_add(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned max_v);
    if (b > (max_v - a)) return max_v;
    return a + b;
  endfunction

endpackage

// File: rtl/pipe_cleaner_elastic_stage.sv
// One elastic pipeline stage: a valid bit plus a data word.
// Ports:
//   clk, rst  : clock and async active-high reset
//   flush_i   : clear the valid bit this edge (highest priority)
//   load_i    : capture d_i and set valid
//   clr_i     : clear valid (the word moved on); load_i wins if both are set
//   d_i       : incoming word
//   v_o, d_o  : registered valid and data
//   v_d_o     : next-state valid, used by the parent for occupancy
module pce_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             load_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             v_o,
  output logic             v_d_o,
  output logic [WIDTH-1:0] d_o
);

  logic             v_q, v_d;
  logic [WIDTH-1:0] d_q, d_d;

  always_comb begin
    v_d = 1'b0;
    if (!flush_i) v_d = load_i | (v_q & ~clr_i);
    d_d = (load_i && !flush_i) ? d_i : d_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign v_o   = v_q;
  assign v_d_o = v_d;
  assign d_o   = d_q;

endmodule

// File: rtl/pipe_cleaner_elastic.sv
// Elastic DEPTH-stage pipeline with collapsing bubbles, a one-cycle flush,
// registered occupancy and a saturating count of words discarded by flush.
// Ports:
//   clk, rst             : clock and async active-high reset
//   in_valid/in_data     : upstream word; in_ready is combinational through the ready chain
//   out_valid/out_data   : last stage; out_ready is the downstream accept
//   flush                : drop all in-flight words (an output transfer on the same cycle still completes)
//   occupancy            : registered count of valid stages
//   flushed_cnt          : saturating count of flushed words; clr_stats zeroes it
module pipe_cleaner_elastic
  import pipe_cleaner_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int DEPTH = DEPTH_D,
  parameter int CNT_W = CNT_W_D
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [occ_w(DEPTH)-1:0]  occupancy,
  output logic [CNT_W-1:0]         flushed_cnt,
  input  logic                     clr_stats
);

  localparam int          OCC_W   = occ_w(DEPTH);
  localparam int unsigned CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic [DEPTH-1:0] v_q, v_d, adv, load, clr;
  logic [WIDTH-1:0] d_q  [DEPTH];
  logic [WIDTH-1:0] d_in [DEPTH];

  logic [OCC_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic             out_xfer;

  function automatic int unsigned popcount(input logic [DEPTH-1:0] v);
    int unsigned n = 0;
    for (int i = 0; i < DEPTH; i++) n += 32'(v[i]);
    return n;
  endfunction

  // Ready chain, evaluated from the output backwards: a stage advances when
  // the stage ahead is empty or is itself advancing.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = v_q[DEPTH-1] & out_ready;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      adv[k] = v_q[k] & (~v_q[k+1] | adv[k+1]);
    end
  end

  assign in_ready = ~flush & (~v_q[0] | adv[0]);

  always_comb begin
    load    = adv << 1;
    load[0] = in_valid & in_ready;
    clr     = adv;
  end

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      if (k == 0) begin : g_head
        assign d_in[k] = in_data;
      end else begin : g_body
        assign d_in[k] = d_q[k-1];
      end

      pce_stage #(.WIDTH(WIDTH)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .load_i  (load[k]),
        .clr_i   (clr[k]),
        .d_i     (d_in[k]),
        .v_o     (v_q[k]),
        .v_d_o   (v_d[k]),
        .d_o     (d_q[k])
      );
    end
  endgenerate

  // A word leaving through the output on a flush cycle counts as delivered,
  // so it is subtracted from the number of words the flush drops.
  assign out_xfer = v_q[DEPTH-1] & out_ready;

  always_comb begin
    occ_d    = OCC_W'(popcount(v_d));
    cnt_base = clr_stats ? '0 : cnt_q;
    cnt_d    = cnt_base;
    if (flush) begin
      cnt_d = CNT_W'(sat_add(32'(cnt_base), popcount(v_q) - 32'(out_xfer), CNT_MAX));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
      cnt_q <= '0;
    end else begin
      occ_q <= occ_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid   = v_q[DEPTH-1];
  assign out_data    = d_q[DEPTH-1];
  assign occupancy   = occ_q;
  assign flushed_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_cleaner_elastic.sv
// Directed bench for pipe_cleaner_elastic. Two instances share every input:
// dut_a uses the default 8-bit statistics counter, dut_s a 2-bit one so
// saturation can be observed on the same traffic.
module tb_pipe_cleaner_elastic;

  logic       clk, rst;
  logic       in_valid, out_ready, flush, clr_stats;
  logic [7:0] in_data;

  logic       in_ready_a, out_valid_a;
  logic [7:0] out_data_a;
  logic [2:0] occ_a;
  logic [7:0] cnt_a;

  logic       in_ready_s, out_valid_s;
  logic [7:0] out_data_s;
  logic [2:0] occ_s;
  logic [1:0] cnt_s;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_cleaner_elastic #(.WIDTH(8), .DEPTH(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_a),
    .out_valid(out_valid_a), .out_data(out_data_a), .out_ready(out_ready),
    .flush(flush), .occupancy(occ_a), .flushed_cnt(cnt_a), .clr_stats(clr_stats)
  );

  pipe_cleaner_elastic #(.WIDTH(8), .DEPTH(4), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_s),
    .out_valid(out_valid_s), .out_data(out_data_s), .out_ready(out_ready),
    .flush(flush), .occupancy(occ_s), .flushed_cnt(cnt_s), .clr_stats(clr_stats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    flush = 1'b0; clr_stats = 1'b0;
    tick();
    chk("rst_out_valid", 32'(out_valid_a), 32'd0);
    chk("rst_occ",       32'(occ_a),       32'd0);
    chk("rst_cnt",       32'(cnt_a),       32'd0);
    chk("rst_in_ready",  32'(in_ready_a),  32'd1);
    #5 rst = 1'b0;

    // Fill with the output stalled, then flush a full pipe.
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 8'(i);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("fill_occ",       32'(occ_a),       32'd4);
    chk("fill_out_data",  32'(out_data_a),  32'h01);
    chk("fill_in_ready",  32'(in_ready_a),  32'd0);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready_a),  32'd0);
    tick();
    flush = 1'b0;
    chk("flush4_cnt_a",   32'(cnt_a),       32'd4);
    chk("flush4_cnt_s",   32'(cnt_s),       32'd3);
    chk("flush4_occ",     32'(occ_a),       32'd0);
    chk("flush4_valid",   32'(out_valid_a), 32'd0);

    // Refill, then assert reset between edges and look before any edge.
    in_valid = 1'b1;
    for (int i = 5; i <= 8; i++) begin
      in_data = 8'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("refill_occ", 32'(occ_a), 32'd4);
    #2 rst = 1'b1;
    #1;
    chk("async_out_valid", 32'(out_valid_a), 32'd0);
    chk("async_out_data",  32'(out_data_a),  32'd0);
    chk("async_occ",       32'(occ_a),       32'd0);
    chk("async_cnt_a",     32'(cnt_a),       32'd0);
    chk("async_cnt_s",     32'(cnt_s),       32'd0);
    #1 rst = 1'b0;

    // Latency: accepted at edge N, visible after edge N+3.
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("lat_n0", 32'(out_valid_a), 32'd0);
    tick();
    chk("lat_n1", 32'(out_valid_a), 32'd0);
    tick();
    chk("lat_n2", 32'(out_valid_a), 32'd0);
    tick();
    chk("lat_n3_valid", 32'(out_valid_a), 32'd1);
    chk("lat_n3_data",  32'(out_data_a),  32'hA5);
    tick();
    chk("lat_gone", 32'(out_valid_a), 32'd0);

    // Streaming 0x00..0x0F at one word per cycle.
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = 8'(i);
      #1;
      chk("stream_in_ready", 32'(in_ready_a), 32'd1);
      tick();
      if (i >= 3) begin
        chk("stream_valid", 32'(out_valid_a), 32'd1);
        chk("stream_data",  32'(out_data_a),  32'(i - 3));
        chk("stream_occ",   32'(occ_a),       32'd4);
      end
    end
    in_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("drain_data", 32'(out_data_a), 32'(13 + j));
    end
    tick();
    chk("drain_empty", 32'(out_valid_a), 32'd0);
    chk("drain_occ",   32'(occ_a),       32'd0);

    // Backpressure with a bubble between two words.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h11;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    in_valid = 1'b1; in_data = 8'h22;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("bp_occ2",  32'(occ_a),      32'd2);
    chk("bp_head",  32'(out_data_a), 32'h11);
    in_valid = 1'b1; in_data = 8'h33;
    tick();
    in_data = 8'h44;
    tick();
    in_data = 8'h55;
    #1;
    chk("bp_full_in_ready", 32'(in_ready_a), 32'd0);
    chk("bp_full_occ",      32'(occ_a),      32'd4);
    tick();
    chk("bp_hold_data", 32'(out_data_a), 32'h11);
    chk("bp_hold_occ",  32'(occ_a),      32'd4);
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready_a), 32'd1);
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    chk("bp_one_out_data", 32'(out_data_a), 32'h22);
    chk("bp_one_out_occ",  32'(occ_a),      32'd4);

    // Flush with a concurrent output transfer: 0x22 is delivered, 3 dropped.
    out_ready = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 8'h66;
    #1;
    chk("fo_in_ready", 32'(in_ready_a), 32'd0);
    chk("fo_out_data", 32'(out_data_a), 32'h22);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("fo_cnt_a", 32'(cnt_a),       32'd3);
    chk("fo_cnt_s", 32'(cnt_s),       32'd3);
    chk("fo_occ",   32'(occ_a),       32'd0);
    chk("fo_valid", 32'(out_valid_a), 32'd0);

    // Two more full flushes: dut_a keeps counting, dut_s stays saturated.
    for (int r = 0; r < 2; r++) begin
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
        in_data = 8'(8'h70 + i);
        tick();
      end
      in_valid = 1'b0;
      chk("sat_fill_occ", 32'(occ_s), 32'd4);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("sat_cnt_a", 32'(cnt_a), 32'(7 + 4 * r));
      chk("sat_cnt_s", 32'(cnt_s), 32'd3);
    end

    // Clear plus flush of two words on the same edge.
    in_valid = 1'b1;
    in_data = 8'h81;
    tick();
    in_data = 8'h82;
    tick();
    in_valid = 1'b0;
    chk("clrf_occ", 32'(occ_a), 32'd2);
    clr_stats = 1'b1; flush = 1'b1;
    tick();
    clr_stats = 1'b0; flush = 1'b0;
    chk("clrf_cnt_a", 32'(cnt_a), 32'd2);
    chk("clrf_cnt_s", 32'(cnt_s), 32'd2);
    chk("clrf_occ0",  32'(occ_a), 32'd0);

    // Flushing an empty pipe adds nothing; clear alone zeroes.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("empty_flush_cnt", 32'(cnt_a), 32'd2);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("clr_cnt_a", 32'(cnt_a), 32'd0);
    chk("clr_cnt_s", 32'(cnt_s), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_cleaner_elastic.md
Name: pipe_cleaner_elastic

Overview:
- Parametrised elastic pipeline of DEPTH stages carrying WIDTH-bit words with a valid/ready handshake on both ends.
- Bubbles collapse: any stage advances whenever the stage ahead is empty or is itself advancing.
- A flush clears every in-flight word in one cycle. Flushed words are counted in a saturating statistics counter.
- Sits between the tile's input capture logic and the output driver, generalising the single-width fixed cleaner to arbitrary width and depth, adding flush and occupancy reporting.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 4, number of pipeline stages (>=2).
- CNT_W, 8, width of the flushed-word statistics counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream word present.
- in_data  in  WIDTH  upstream word.
- in_ready  out  1  stage 0 can accept this cycle.
- out_valid  out  1  last stage holds a word.
- out_data  out  WIDTH  word in last stage.
- out_ready  in  1  downstream accepts.
- flush  in  1  clear all stages this cycle.
- occupancy  out  $clog2(DEPTH+1)  number of valid stages (registered).
- flushed_cnt  out  CNT_W  saturating count of words discarded by flush.
- clr_stats  in  1  synchronous clear of flushed_cnt.

Behaviour:
- Reset (async, active-high): all stage valid bits 0, stage data 0, occupancy 0, flushed_cnt 0, out_valid 0, out_data 0. Outputs reflect reset immediately, without waiting for a clock edge.
- Stage k (0..DEPTH-1, with DEPTH-1 being the output stage) holds v[k] and d[k].
- adv[DEPTH-1] = v[DEPTH-1] & out_ready. For k<DEPTH-1: adv[k] = v[k] & (!v[k+1] | adv[k+1]).
- in_ready = !v[0] | adv[0]. This path is combinational through the ready chain; there is no skid buffer.
- Per edge, no flush, stage k>0:
  - if adv[k-1]: load d[k-1] and set v[k].
  - else if adv[k]: clear v[k].
  - else: hold.
- Stage 0 loads in_data when in_valid & in_ready.
- Latency: with an empty pipe and out_ready held high, a word accepted at edge N appears on out_valid after edge N+DEPTH-1. Throughput is 1 word per cycle.
- out_valid = v[DEPTH-1]; out_data = d[DEPTH-1]. Data is not modified in flight.
- Flush has priority over everything:
  - On an edge with flush=1, all v[k] clear.
  - in_ready is forced 0 during flush, so no input is accepted.
  - Output transfers on that cycle still complete: an out_valid&out_ready word counts as delivered, not flushed.
  - flushed_cnt += popcount(v) minus 1 if the output transfer occurred. Saturates at 2^CNT_W-1, no wrap.
- clr_stats=1 sets flushed_cnt to 0 at the edge. If a flush occurs on the same edge, the result is the flush's popcount (clear first, then add).
- occupancy is updated every edge to the next-state popcount of v. Range 0..DEPTH.
- Full: all v set and out_ready=0 gives in_ready=0; in_valid is ignored and data is held.
- Full with out_ready=1: the entire chain advances and in_ready=1 in the same cycle.
- Empty: out_valid=0; out_ready is don't-care.
- Data registers of invalid stages may hold stale values; only the valid bits are architecturally visible.
- Reset asserted mid-operation: all contents are lost and are not counted in flushed_cnt.

Decomposition:
- Package pipe_cleaner_pkg holds:
  - the occupancy width function, occ_w(DEPTH) = $clog2(DEPTH+1);
  - the saturating-add helper;
  - the default constants WIDTH_D=8, DEPTH_D=4, CNT_W_D=8.
- Sub-module pce_stage (one valid+data register with load/clear/hold controls and flush) is instantiated DEPTH times in a generate loop.
- The ready chain, popcount and counter live in the top module.

Test Plan:
- Reset/latency, DEPTH=4: assert rst async mid-cycle -> out_valid=0, occupancy=0, flushed_cnt=0 without a clock edge. Then send 0xA5 with out_ready=1 -> out_valid=1, out_data=0xA5 exactly 3 edges after acceptance.
- Streaming: 16 consecutive words 0x00..0x0F, in_valid=out_ready=1 -> in_ready stays 1, outputs are 0x00..0x0F in order with no gaps, occupancy steady at 4.
- Backpressure/bubble collapse: send 0x11, idle 2 cycles, send 0x22, hold out_ready=0.
  - Both words pack into stages 3 and 2; occupancy=2.
  - Fill to 4 words -> in_ready=0.
  - Release out_ready for 1 cycle -> exactly one word out and in_ready=1 the same cycle.
- Flush with concurrent output: 4 valid words, out_ready=1, flush=1 -> one word delivered, flushed_cnt=3, occupancy=0 next cycle, in_ready=0 during the flush cycle.
- Saturation/clear: CNT_W=2, flush a full pipe (4 words, out_ready=0) twice -> flushed_cnt=3 (saturated). Then clr_stats with a simultaneous flush of 2 words -> flushed_cnt=2.
- Parametrisation: WIDTH=1,DEPTH=2 and WIDTH=32,DEPTH=8 run the streaming and flush scenarios against a reference queue model -> zero mismatches over 10k random valid/ready/flush cycles.
